// File: rtl/vx_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// vx_mem_arb_pkg
// Shared definitions for the Vortex memory-port arbiter:
//   - default configuration widths used by vx_mem_port_arbiter
//   - helper functions deriving the requester-index width and extended tag width
//   - the request bundle carried from a requester to the shared memory port
//     (typedef sized by the default configuration)
// -----------------------------------------------------------------------------
package vx_mem_arb_pkg;

  localparam int ARB_DATA_WIDTH   = 512;
  localparam int ARB_ADDR_WIDTH   = 26;
  localparam int ARB_TAG_IN_WIDTH = 8;
  localparam int ARB_BYTEEN_WIDTH = ARB_DATA_WIDTH / 8;

  // Width of a requester index; at least one bit so a 1-bit tag extension exists.
  function automatic int calc_log_reqs(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Downstream tag = requester tag with the requester index appended as LSBs.
  function automatic int calc_tag_out_width(input int tag_in_width, input int num_reqs);
    return tag_in_width + calc_log_reqs(num_reqs);
  endfunction

  typedef struct packed {
    logic                        rw;
    logic [ARB_BYTEEN_WIDTH-1:0] byteen;
    logic [ARB_ADDR_WIDTH-1:0]   addr;
    logic [ARB_DATA_WIDTH-1:0]   data;
    logic [ARB_TAG_IN_WIDTH-1:0] tag;
  } mem_req_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vx_rr_arbiter
// Round-robin arbiter with an external grant lock.
//   clk, reset     : clock, synchronous active-high reset
//   requests       : per-requester eligibility
//   lock, lock_idx : when lock is set, lock_idx is granted unconditionally
//   advance        : a grant was consumed; priority moves past the winner
//   grant_onehot   : one-hot grant (zero when nothing is granted)
//   grant_idx      : binary grant index
//   grant_valid    : a grant is being issued this cycle
// Owns the priority pointer: the search starts at prio_q and wraps.
// -----------------------------------------------------------------------------
module vx_rr_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int LOG_REQS = calc_log_reqs(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                lock,
  input  logic [LOG_REQS-1:0] lock_idx,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [LOG_REQS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [LOG_REQS-1:0] prio_q, prio_d;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise paths that skip an assignment would infer a latch.
    idx          = 0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    if (lock) begin
      grant_idx   = lock_idx;
      grant_valid = 1'b1;
    end else begin
      // Scan from farthest to nearest so the last hit is the first eligible
      // index at or after prio_q.
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        idx = int'(prio_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        if (requests[idx]) begin
          grant_idx   = LOG_REQS'(idx);
          grant_valid = 1'b1;
        end
      end
    end
    grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_idx) : '0;
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      prio_d = (grant_idx == LOG_REQS'(NUM_REQS - 1)) ? '0 : grant_idx + LOG_REQS'(1);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers sample their inputs from the same clock edge.
  always_ff @(posedge clk) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/vx_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// vx_mem_port_arbiter
// Shares one Vortex memory request/response port among NUM_REQS requesters.
//   clk, reset                : clock, synchronous active-high reset
//   req_valid/rw/ready        : per-requester request handshake (rw=1 write)
//   req_byteen/addr/data/tag  : per-requester request payload
//   rsp_valid/ready           : per-requester response handshake
//   rsp_data/rsp_tag          : response payload, broadcast to all requesters
//   mem_req_*                 : downstream request; tag = {req_tag, index}
//   mem_rsp_*                 : downstream response; tag LSBs select requester
// A grant is held until the downstream accepts it, and each requester may have
// at most MAX_PENDING reads outstanding (writes return no response).
// -----------------------------------------------------------------------------
module vx_mem_port_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter  int NUM_REQS      = 4,
  parameter  int DATA_WIDTH    = ARB_DATA_WIDTH,
  parameter  int ADDR_WIDTH    = ARB_ADDR_WIDTH,
  parameter  int TAG_IN_WIDTH  = ARB_TAG_IN_WIDTH,
  parameter  int MAX_PENDING   = 16,
  localparam int LOG_REQS      = calc_log_reqs(NUM_REQS),
  localparam int TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS-1:0]                     req_valid,
  input  logic [NUM_REQS-1:0]                     req_rw,
  input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]   req_byteen,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]                     req_ready,
  output logic [NUM_REQS-1:0]                     rsp_valid,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     rsp_data,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]   rsp_tag,
  input  logic [NUM_REQS-1:0]                     rsp_ready,
  output logic                                    mem_req_valid,
  output logic                                    mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]                 mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
  output logic [DATA_WIDTH-1:0]                   mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]                mem_req_tag,
  input  logic                                    mem_req_ready,
  input  logic                                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                   mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]                mem_rsp_tag,
  output logic                                    mem_rsp_ready
);

  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] grant_onehot;
  logic [LOG_REQS-1:0] grant_idx;
  logic                grant_valid;
  logic                req_fire, rsp_fire;
  logic [LOG_REQS-1:0] rsp_idx;

  logic                lock_q, lock_d;
  logic [LOG_REQS-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_WIDTH-1:0] pend_cnt_q [NUM_REQS];
  logic [CNT_WIDTH-1:0] pend_cnt_d [NUM_REQS];

  // Reads at the cap are held back at grant time; writes are never capped.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid[i] && (req_rw[i] || pend_cnt_q[i] != CNT_WIDTH'(MAX_PENDING));
    end
  end

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (eligible),
    .lock         (lock_q),
    .lock_idx     (lock_idx_q),
    .advance      (req_fire),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  // ---------------- request path ----------------
  assign mem_req_valid  = !reset && grant_valid && req_valid[grant_idx];
  assign mem_req_rw     = req_rw[grant_idx];
  assign mem_req_byteen = req_byteen[grant_idx];
  assign mem_req_addr   = req_addr[grant_idx];
  assign mem_req_data   = req_data[grant_idx];
  assign mem_req_tag    = {req_tag[grant_idx], grant_idx};
  assign req_fire       = mem_req_valid && mem_req_ready;
  // Ready only reaches the requester that actually holds the port.
  assign req_ready      = mem_req_valid ? (grant_onehot & {NUM_REQS{mem_req_ready}}) : '0;

  // Hold the grant across downstream back-pressure so the adapter sees a
  // stable request until it completes both halves of its handshake.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (mem_req_valid && !mem_req_ready) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end else if (req_fire) begin
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------- response path ----------------
  assign rsp_idx       = mem_rsp_tag[LOG_REQS-1:0];
  assign mem_rsp_ready = !reset && rsp_ready[rsp_idx];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  always_comb begin
    rsp_valid = '0;
    if (!reset) rsp_valid[rsp_idx] = mem_rsp_valid;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data[i] = mem_rsp_data;
      rsp_tag[i]  = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS];
    end
  end

  // ---------------- outstanding-read counters ----------------
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc           = req_fire && !mem_req_rw && (grant_idx == LOG_REQS'(i));
      dec           = rsp_fire && (rsp_idx == LOG_REQS'(i));
      pend_cnt_d[i] = pend_cnt_q[i];
      if (inc && !dec) begin
        pend_cnt_d[i] = pend_cnt_q[i] + CNT_WIDTH'(1);
      end else if (dec && !inc && pend_cnt_q[i] != '0) begin
        // An unexpected response saturates at zero instead of wrapping.
        pend_cnt_d[i] = pend_cnt_q[i] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) pend_cnt_q[i] <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // A response for a requester with no reads outstanding is a protocol error.
  assert property (@(posedge clk) disable iff (reset)
    !(rsp_fire && pend_cnt_q[rsp_idx] == '0));

endmodule

// File: doc/vx_mem_port_arbiter.md
# vx_mem_port_arbiter

Round-robin arbiter that shares one Vortex memory request/response port among NUM_REQS requesters. It sits upstream of the Vortex-to-AXI adapter. The arbiter holds each grant until the downstream handshake completes, which the adapter's split AW/W acknowledgement requires. It extends tags with the requester index so read responses route back to their source, and it caps outstanding reads per requester.

## Interface
Parameters:
- NUM_REQS, 4: number of requesters, ≥2.
- DATA_WIDTH, 512: data width in bits.
- ADDR_WIDTH, 26: line address width in bits.
- TAG_IN_WIDTH, 8: requester tag width.
- MAX_PENDING, 16: maximum outstanding reads per requester.
- Derived: LOG_REQS = $clog2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH+LOG_REQS; BYTEEN_WIDTH = DATA_WIDTH/8; CNT_WIDTH = $clog2(MAX_PENDING+1).

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid / req_rw / req_ready  in / in / out  NUM_REQS  per-requester handshake; rw=1 means write.
- req_byteen  in  NUM_REQS×BYTEEN_WIDTH  byte enables.
- req_addr  in  NUM_REQS×ADDR_WIDTH  addresses.
- req_data  in  NUM_REQS×DATA_WIDTH  write data.
- req_tag  in  NUM_REQS×TAG_IN_WIDTH  tags.
- rsp_valid / rsp_ready  out / in  NUM_REQS  per-requester response handshake.
- rsp_data  out  NUM_REQS×DATA_WIDTH  response data, broadcast to all requesters.
- rsp_tag  out  NUM_REQS×TAG_IN_WIDTH  response tag, broadcast to all requesters.
- mem_req_valid / mem_req_rw  out  1  downstream request.
- mem_req_byteen / mem_req_addr / mem_req_data  out  BYTEEN_WIDTH / ADDR_WIDTH / DATA_WIDTH  downstream request fields.
- mem_req_tag  out  TAG_OUT_WIDTH  extended tag, {req_tag, index}.
- mem_req_ready  in  1  downstream accept.
- mem_rsp_valid  in  1  downstream response valid.
- mem_rsp_data  in  DATA_WIDTH  downstream response data.
- mem_rsp_tag  in  TAG_OUT_WIDTH  downstream response tag.
- mem_rsp_ready  out  1  downstream response accept.

## Operation
- Eligibility: requester i is eligible when req_valid[i] is high and it is not a read with pend_cnt[i]==MAX_PENDING.
- Grant selection: when unlocked, grant the first eligible index at or after prio_ptr, circularly. When locked, grant lock_idx unconditionally.
- Lock: set when mem_req_valid && !mem_req_ready; lock_idx <= grant. Cleared on fire. Requesters must hold valid and payload stable until ready.
- Request path: mem_req_* = the fields of the granted requester; mem_req_tag = {req_tag[g], g[LOG_REQS-1:0]}. req_ready[g] = mem_req_ready; all other req_ready bits are 0.
- Priority update: on fire, prio_ptr <= (g+1) mod NUM_REQS; wrap from NUM_REQS-1 to 0. prio_ptr is unchanged otherwise.
- Counters: pend_cnt[i] increments on a read fire from i. It decrements on mem_rsp fire whose tag LSBs equal i. A simultaneous increment and decrement leaves it unchanged. Writes are not counted (no write response is returned).
- Response path: with r = mem_rsp_tag[LOG_REQS-1:0]:
  - rsp_valid[r] = mem_rsp_valid; all other rsp_valid bits are 0.
  - rsp_tag = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS], broadcast.
  - rsp_data = mem_rsp_data, broadcast.
  - mem_rsp_ready = rsp_ready[r].
- Error case: a response for index i with pend_cnt[i]==0 is an error. It fires a runtime assertion and the counter saturates at 0.

## Timing
- Latency: the request and response paths are combinational, zero cycles. The only state is prio_ptr, the lock bit, lock_idx and pend_cnt.
- Reset values: prio_ptr=0, lock=0, lock_idx=0, all pend_cnt=0.
- Outputs during reset: mem_req_valid=0, req_ready=0, rsp_valid=0, mem_rsp_ready=0.
- Reset mid-operation: a held, locked request is dropped and outstanding counts are lost. Downstream must also be reset.
- Back-pressure: mem_req_ready low for N cycles keeps the same grant for N+1 cycles, even if higher-priority requesters assert valid.
- Cap: the cap is applied at grant time. A requester at the cap that is already locked cannot occur, because a locked request is already eligible.
- Throughput: one request per cycle when mem_req_ready stays high; the grant rotates every cycle.

## Structure
- Package vx_mem_arb_pkg holds:
  - the LOG_REQS/TAG_OUT_WIDTH derivation functions;
  - the request struct type (rw, byteen, addr, data, tag), parameterised via localparams in the package.
- Sub-module vx_rr_arbiter (NUM_REQS): inputs requests, lock, lock_idx and advance; outputs one-hot and binary grant; owns prio_ptr.
- Per-requester counters and the muxes/demuxes live in the top module.

## Test plan
- All 4 requesters issue reads with mem_req_ready=1 continuously -> grants 0,1,2,3,0,… one per cycle; mem_req_tag LSBs match the granting index.
- Requester 2 writes while mem_req_ready is held low 3 cycles and requester 0 raises valid in the middle -> grant stays on 2 for 4 cycles; then 0 is served next cycle.
- Requester 1 issues 16 reads with no responses and MAX_PENDING=16 -> 17th read is not granted, while requester 3's reads proceed. One response with tag LSBs=1 -> requester 1 is granted the next cycle.
- Response with mem_rsp_tag={8'hA5, 2'd3} and rsp_ready[3]=0 -> rsp_valid[3]=1, rsp_tag=8'hA5, mem_rsp_ready=0, and the counter is unchanged until rsp_ready[3]=1.
- Read fire from requester 0 in the same cycle as a response to requester 0 -> pend_cnt[0] is unchanged.
- Reset asserted while a write is locked -> the next cycle shows prio_ptr=0, lock=0, all counters 0 and mem_req_valid=0.
